// File: rtl/memory_access_stage.sv
// memory_access_stage: pipeline MA stage with data-memory handshake,
// store lane shifting, load alignment/extension and the MA/WB register.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   *_in                - EX/MA pipeline register contents
//   dmem_rdata/resp     - data-memory response (resp is a 1-cycle pulse)
//   dmem_read/write     - request strobes, held until the response cycle
//   dmem_address/wdata/byte_enable - request payload
//   MA_stall            - freezes EX/MA and upstream while a memop waits
//   *_out, mem_wb_data  - MA/WB register and writeback/forwarding value

package rv32i_types;

   typedef logic [31:0] rv32i_word;

   typedef enum logic [6:0] {
      op_lui   = 7'b0110111,
      op_auipc = 7'b0010111,
      op_jal   = 7'b1101111,
      op_jalr  = 7'b1100111,
      op_br    = 7'b1100011,
      op_load  = 7'b0000011,
      op_store = 7'b0100011,
      op_imm   = 7'b0010011,
      op_reg   = 7'b0110011,
      op_csr   = 7'b1110011
   } rv32i_opcode;

   typedef struct packed {
      rv32i_opcode opcode;
      logic        load_regfile;
      logic [4:0]  rd;
   } rv32i_control_word;

endpackage

module memory_access_stage
   import rv32i_types::*;
(
   input  logic              clk,
   input  logic              rst,
   input  rv32i_control_word ctrl_word_in,
   input  rv32i_word         instruction_in,
   input  rv32i_word         PC_in,
   input  rv32i_word         alu_out_in,
   input  rv32i_word         rs2_in,
   input  logic              br_en_in,
   input  logic [3:0]        mem_byte_enable_in,
   input  rv32i_word         dmem_rdata,
   input  logic              dmem_resp,
   output logic              dmem_read,
   output logic              dmem_write,
   output rv32i_word         dmem_address,
   output rv32i_word         dmem_wdata,
   output logic [3:0]        dmem_byte_enable,
   output logic              MA_stall,
   output rv32i_control_word ctrl_word_out,
   output rv32i_word         instruction_out,
   output rv32i_word         PC_out,
   output rv32i_word         alu_out_out,
   output logic              br_en_out,
   output rv32i_word         mem_rdata_out,
   output rv32i_word         mem_wb_data
);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t     state;
   state_t     next_state;
   logic       is_load;
   logic       is_store;
   logic       memop;
   logic [2:0] funct3;
   logic [4:0] lane_sh;
   rv32i_word  shifted;
   rv32i_word  load_val;

   assign is_load  = (ctrl_word_in.opcode == op_load);
   assign is_store = (ctrl_word_in.opcode == op_store);
   assign memop    = is_load | is_store;
   assign funct3   = instruction_in[14:12];
   assign lane_sh  = {alu_out_in[1:0], 3'b000};

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: if (memop && !dmem_resp) next_state = BUSY;
         BUSY: if (dmem_resp)           next_state = IDLE;
      endcase
   end

   // Request stays up through the response cycle in either state;
   // a same-cycle response therefore never raises the stall.
   always_comb begin
      dmem_read  = 1'b0;
      dmem_write = 1'b0;
      MA_stall   = 1'b0;
      if (!rst) begin
         unique case (state)
            IDLE, BUSY: begin
               dmem_read  = is_load;
               dmem_write = is_store;
               MA_stall   = memop && !dmem_resp;
            end
         endcase
      end
   end

   assign dmem_address     = {alu_out_in[31:2], 2'b00};
   assign dmem_byte_enable = mem_byte_enable_in;
   assign dmem_wdata       = (funct3 == 3'b010) ? rs2_in
                                                : (rs2_in << lane_sh);

   assign shifted = dmem_rdata >> lane_sh;

   always_comb begin
      load_val = dmem_rdata;
      unique case (1'b1)
         (funct3 == 3'b000): load_val = {{24{shifted[7]}}, shifted[7:0]};
         (funct3 == 3'b100): load_val = {24'h0, shifted[7:0]};
         (funct3 == 3'b001): load_val = {{16{shifted[15]}}, shifted[15:0]};
         (funct3 == 3'b101): load_val = {16'h0, shifted[15:0]};
         default:            load_val = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ctrl_word_out   <= '0;
         instruction_out <= '0;
         PC_out          <= '0;
         alu_out_out     <= '0;
         br_en_out       <= 1'b0;
         mem_rdata_out   <= '0;
      end else if (!MA_stall) begin
         ctrl_word_out   <= ctrl_word_in;
         instruction_out <= instruction_in;
         PC_out          <= PC_in;
         alu_out_out     <= alu_out_in;
         br_en_out       <= br_en_in;
         mem_rdata_out   <= is_load ? load_val : '0;
      end
   end

   assign mem_wb_data = (ctrl_word_out.opcode == op_load) ? mem_rdata_out
                                                          : alu_out_out;

endmodule

// File: tb/tb_memory_access_stage.sv
// tb_memory_access_stage: directed self-checking bench for the MA stage.
// Inputs change 1ns after posedge; outputs are sampled on negedge.

module tb_memory_access_stage;
   import rv32i_types::*;

   logic              clk = 1'b0;
   logic              rst;
   rv32i_control_word ctrl_word_in;
   rv32i_word         instruction_in;
   rv32i_word         PC_in;
   rv32i_word         alu_out_in;
   rv32i_word         rs2_in;
   logic              br_en_in;
   logic [3:0]        mem_byte_enable_in;
   rv32i_word         dmem_rdata;
   logic              dmem_resp;
   logic              dmem_read;
   logic              dmem_write;
   rv32i_word         dmem_address;
   rv32i_word         dmem_wdata;
   logic [3:0]        dmem_byte_enable;
   logic              MA_stall;
   rv32i_control_word ctrl_word_out;
   rv32i_word         instruction_out;
   rv32i_word         PC_out;
   rv32i_word         alu_out_out;
   logic              br_en_out;
   rv32i_word         mem_rdata_out;
   rv32i_word         mem_wb_data;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   memory_access_stage dut (
      .clk                (clk),
      .rst                (rst),
      .ctrl_word_in       (ctrl_word_in),
      .instruction_in     (instruction_in),
      .PC_in              (PC_in),
      .alu_out_in         (alu_out_in),
      .rs2_in             (rs2_in),
      .br_en_in           (br_en_in),
      .mem_byte_enable_in (mem_byte_enable_in),
      .dmem_rdata         (dmem_rdata),
      .dmem_resp          (dmem_resp),
      .dmem_read          (dmem_read),
      .dmem_write         (dmem_write),
      .dmem_address       (dmem_address),
      .dmem_wdata         (dmem_wdata),
      .dmem_byte_enable   (dmem_byte_enable),
      .MA_stall           (MA_stall),
      .ctrl_word_out      (ctrl_word_out),
      .instruction_out    (instruction_out),
      .PC_out             (PC_out),
      .alu_out_out        (alu_out_out),
      .br_en_out          (br_en_out),
      .mem_rdata_out      (mem_rdata_out),
      .mem_wb_data        (mem_wb_data)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic set_op(input rv32i_opcode op,
                         input logic [2:0]  f3,
                         input logic [31:0] alu,
                         input logic [31:0] rs2,
                         input logic [3:0]  be);
      ctrl_word_in.opcode       = op;
      ctrl_word_in.load_regfile = (op != op_store);
      ctrl_word_in.rd           = 5'd1;
      instruction_in            = {17'h0, f3, 5'd1, op};
      PC_in                     = PC_in + 32'd4;
      alu_out_in                = alu;
      rs2_in                    = rs2;
      mem_byte_enable_in        = be;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // n stall cycles, then the response cycle; leaves resp low after edge
   task automatic do_mem(input string tag,
                         input int n,
                         input logic [31:0] rdata,
                         input logic [31:0] e_addr,
                         input logic [31:0] e_wdata,
                         input logic [3:0]  e_be,
                         input logic        e_rd,
                         input logic        e_wr);
      dmem_resp = 1'b0;
      for (int i = 0; i <= n; i++) begin
         if (i == n) begin
            dmem_resp  = 1'b1;
            dmem_rdata = rdata;
         end
         @(negedge clk);
         check({tag, "_stall"}, {31'h0, MA_stall}, {31'h0, (i != n)});
         check({tag, "_addr"}, dmem_address, e_addr);
         check({tag, "_wdata"}, dmem_wdata, e_wdata);
         check({tag, "_be"}, {28'h0, dmem_byte_enable}, {28'h0, e_be});
         check({tag, "_rd"}, {31'h0, dmem_read}, {31'h0, e_rd});
         check({tag, "_wr"}, {31'h0, dmem_write}, {31'h0, e_wr});
         step();
      end
      dmem_resp  = 1'b0;
      dmem_rdata = 32'h0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation ran past time limit");
      $fatal(1, "timeout");
   end

   initial begin
      rst          = 1'b1;
      ctrl_word_in = '0;
      PC_in        = 32'h0;
      br_en_in     = 1'b0;
      dmem_rdata   = 32'h0;
      dmem_resp    = 1'b0;
      set_op(op_load, 3'b010, 32'h0000_0100, 32'h0, 4'hF);

      // reset cycle: requests low even with a load present
      @(negedge clk);
      check("rst_rd", {31'h0, dmem_read}, 32'h0);
      check("rst_stall", {31'h0, MA_stall}, 32'h0);
      step();
      check("rst_wb", mem_wb_data, 32'h0);
      check("rst_pc", PC_out, 32'h0);
      rst = 1'b0;

      // add passes in one cycle
      set_op(op_reg, 3'b000, 32'h0000_1234, 32'h0, 4'h0);
      @(negedge clk);
      check("add_stall", {31'h0, MA_stall}, 32'h0);
      check("add_rd", {31'h0, dmem_read}, 32'h0);
      step();
      set_op(op_imm, 3'b000, 32'h0000_0001, 32'h0, 4'h0);
      @(negedge clk);
      check("add_wb", mem_wb_data, 32'h0000_1234);
      check("add_rdata", mem_rdata_out, 32'h0);
      step();

      // lb, 3-cycle wait
      set_op(op_load, 3'b000, 32'h0000_1003, 32'h0, 4'b1000);
      do_mem("lb", 3, 32'h80FF_7F01, 32'h0000_1000, 32'h0, 4'b1000,
             1'b1, 1'b0);
      set_op(op_imm, 3'b000, 32'h0000_0002, 32'h0, 4'h0);
      @(negedge clk);
      check("lb_wb", mem_wb_data, 32'hFFFF_FF80);
      step();

      // lbu, same access
      set_op(op_load, 3'b100, 32'h0000_1003, 32'h0, 4'b1000);
      do_mem("lbu", 3, 32'h80FF_7F01, 32'h0000_1000, 32'h0, 4'b1000,
             1'b1, 1'b0);
      set_op(op_imm, 3'b000, 32'h0000_0003, 32'h0, 4'h0);
      @(negedge clk);
      check("lbu_wb", mem_wb_data, 32'h0000_0080);
      step();

      // sh into upper halfword
      set_op(op_store, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 4'b1100);
      do_mem("sh", 2, 32'h0, 32'h0000_2000, 32'hBEEF_0000, 4'b1100,
             1'b0, 1'b1);
      set_op(op_imm, 3'b000, 32'h0000_0004, 32'h0, 4'h0);
      @(negedge clk);
      check("sh_wb", mem_wb_data, 32'h0000_2002);
      check("sh_rdata", mem_rdata_out, 32'h0);
      step();

      // lw with zero-wait response
      set_op(op_load, 3'b010, 32'h0000_3000, 32'h0, 4'hF);
      do_mem("lw0", 0, 32'hDEAD_BEEF, 32'h0000_3000, 32'h0, 4'hF,
             1'b1, 1'b0);
      set_op(op_imm, 3'b000, 32'h0000_0005, 32'h0, 4'h0);
      @(negedge clk);
      check("lw0_wb", mem_wb_data, 32'hDEAD_BEEF);
      step();

      // back-to-back loads, 1-cycle wait each
      set_op(op_load, 3'b010, 32'h0000_4000, 32'h0, 4'hF);
      do_mem("b2b1", 1, 32'h1111_1111, 32'h0000_4000, 32'h0, 4'hF,
             1'b1, 1'b0);
      set_op(op_load, 3'b101, 32'h0000_4006, 32'h0, 4'b1100);
      @(negedge clk);
      check("b2b_first_wb", mem_wb_data, 32'h1111_1111);
      check("b2b2_stall", {31'h0, MA_stall}, 32'h1);
      check("b2b2_rd", {31'h0, dmem_read}, 32'h1);
      step();
      dmem_resp  = 1'b1;
      dmem_rdata = 32'hABCD_0000;
      @(negedge clk);
      check("b2b2_resp_stall", {31'h0, MA_stall}, 32'h0);
      check("b2b2_hold_wb", mem_wb_data, 32'h1111_1111);
      step();
      dmem_resp = 1'b0;
      set_op(op_imm, 3'b000, 32'h0000_0006, 32'h0, 4'h0);
      @(negedge clk);
      check("b2b_second_wb", mem_wb_data, 32'h0000_ABCD);
      step();

      // reset while BUSY
      set_op(op_load, 3'b010, 32'h0000_5000, 32'h0, 4'hF);
      @(negedge clk);
      check("rb_rd", {31'h0, dmem_read}, 32'h1);
      check("rb_stall", {31'h0, MA_stall}, 32'h1);
      step();
      rst = 1'b1;
      @(negedge clk);
      check("rb_rst_rd", {31'h0, dmem_read}, 32'h0);
      check("rb_rst_stall", {31'h0, MA_stall}, 32'h0);
      step();
      rst = 1'b0;
      set_op(op_reg, 3'b000, 32'h0000_0077, 32'h0, 4'h0);
      @(negedge clk);
      check("rb_wb", mem_wb_data, 32'h0);
      check("rb_alu", alu_out_out, 32'h0);
      check("rb_pc", PC_out, 32'h0);
      check("rb_fsm", {31'h0, dut.state}, 32'h0);
      check("rb_add_stall", {31'h0, MA_stall}, 32'h0);
      step();
      set_op(op_imm, 3'b000, 32'h0000_0099, 32'h0, 4'h0);
      @(negedge clk);
      check("rb_add_wb", mem_wb_data, 32'h0000_0077);
      step();

      // response coinciding with reset: nothing captured
      set_op(op_load, 3'b010, 32'h0000_6000, 32'h0, 4'hF);
      rst        = 1'b1;
      dmem_resp  = 1'b1;
      dmem_rdata = 32'h1234_5678;
      @(negedge clk);
      check("rr_pre_wb", mem_wb_data, 32'h0000_0099);
      check("rr_rd", {31'h0, dmem_read}, 32'h0);
      step();
      rst       = 1'b0;
      dmem_resp = 1'b0;
      set_op(op_imm, 3'b000, 32'h0000_0000, 32'h0, 4'h0);
      @(negedge clk);
      check("rr_wb", mem_wb_data, 32'h0);
      check("rr_rdata", mem_rdata_out, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Pipeline memory-access (MA) stage sitting directly downstream of the execute stage. It consumes the EX/MA pipeline register (control word, instruction, PC, ALU result, store data, branch flag, byte enables) and performs the data-memory transaction for loads and stores through a request/response handshake. It stalls the pipeline while a transaction is outstanding and aligns and extends load data. Its MA/WB pipeline register feeds writeback and the execute-stage forwarding path.

## Interface
- No parameters; widths follow `rv32i_types` (`rv32i_word` = 32 bits).
- `clk` in 1: pipeline clock.
- `rst` in 1: synchronous, active-high reset.
- `ctrl_word_in` in `rv32i_control_word`: EX/MA control word; uses `.opcode`.
- `instruction_in` in 32: EX/MA instruction; funct3 = [14:12].
- `PC_in` in 32: EX/MA PC.
- `alu_out_in` in 32: ALU result; this is the byte address for loads and stores.
- `rs2_in` in 32: store source data.
- `br_en_in` in 1: EX branch result, passed through.
- `mem_byte_enable_in` in 4: byte enables computed by EX.
- `dmem_rdata` in 32: data-memory read data, valid with `dmem_resp`.
- `dmem_resp` in 1: data-memory completion, a one-cycle pulse.
- `dmem_read` out 1: read request.
- `dmem_write` out 1: write request.
- `dmem_address` out 32: `{alu_out_in[31:2], 2'b00}`.
- `dmem_wdata` out 32: store data shifted into lane position.
- `dmem_byte_enable` out 4: equals `mem_byte_enable_in`.
- `MA_stall` out 1: holds the EX/MA register and all upstream registers.
- `ctrl_word_out`, `instruction_out`, `PC_out` out: MA/WB copies.
- `alu_out_out` out 32: MA/WB ALU result.
- `br_en_out` out 1: MA/WB branch flag.
- `mem_rdata_out` out 32: aligned, extended load value.
- `mem_wb_data` out 32: writeback/forwarding value; load value for loads, `alu_out_out` otherwise.

## Operation
- memop = `ctrl_word_in.opcode` is `op_load` or `op_store`.
- FSM states:
  - IDLE (reset state):
    - If memop and `dmem_resp`: stay IDLE.
    - If memop and no `dmem_resp`: go to BUSY.
    - If not memop: stay IDLE.
  - BUSY: on `dmem_resp` go to IDLE; otherwise stay in BUSY.
- Request signals:
  - `dmem_read` = memop && load && !rst, asserted in both IDLE and BUSY until the response cycle inclusive.
  - `dmem_write` is the same, for stores.
  - `dmem_address`, `dmem_wdata` and `dmem_byte_enable` are held stable while the request is asserted; the EX/MA inputs are frozen by `MA_stall`.
- `MA_stall` = memop && !`dmem_resp` && !rst. It is combinational, so a zero-wait response causes no stall.
- `dmem_resp` is ignored when no memop is present.
- Store data: `dmem_wdata = rs2_in << (8*alu_out_in[1:0])` for sb and sh; `rs2_in` for sw.
- Load extension. Let off = `alu_out_in[1:0]` and shifted = `dmem_rdata >> (8*off)`:
  - lb: sign-extend shifted[7:0].
  - lbu: zero-extend shifted[7:0].
  - lh: sign-extend shifted[15:0].
  - lhu: zero-extend shifted[15:0].
  - lw: `dmem_rdata`.
  - Misaligned halfword or word accesses are not supported. The result is whatever the shift yields; no trap is raised.
- MA/WB register:
  - Captures all `*_out` values when !`MA_stall`.
  - For non-loads, `mem_rdata_out` captures 0.
  - For stores, the register captures in the response cycle.

## Timing
- Reset: all MA/WB outputs go to 0, FSM goes to IDLE, and `dmem_read`, `dmem_write` and `MA_stall` are 0 during the `rst` cycle.
- Non-memory instruction: one cycle from EX/MA to MA/WB.
- Load or store with a response N cycles after the request first asserts (N=0 means the same cycle):
  - `MA_stall` is high for exactly N cycles.
  - MA/WB updates at the edge ending the response cycle.
- Back-to-back memops: the next request asserts in the cycle after the response, with no idle bubble.
- Reset in BUSY: the FSM returns to IDLE and requests drop in the `rst` cycle. The memory side is reset together with this stage, so no stale response follows.
- `dmem_resp` coinciding with `rst`: reset wins and nothing is captured.

## Test plan
- add result `alu_out_in=0x00001234`, no memop:
  - `MA_stall` stays 0.
  - Next cycle `mem_wb_data=0x00001234` and `mem_rdata_out=0`.
- lb at 0x00001003, resp after 3 cycles with `dmem_rdata=0x80FF7F01`:
  - `dmem_address=0x00001000`.
  - `MA_stall` is high for 3 cycles.
  - `mem_wb_data=0xFFFFFF80`.
  - Repeating as lbu gives 0x00000080.
- sh at 0x00002002, `rs2_in=0x0000BEEF`, `mem_byte_enable_in=4'b1100`:
  - `dmem_write=1`, `dmem_address=0x00002000`, `dmem_wdata=0xBEEF0000`, `dmem_byte_enable=4'b1100`.
  - Signals stay stable until resp.
- lw at 0x00003000 with resp in the same cycle and `dmem_rdata=0xDEADBEEF`:
  - No stall.
  - Next cycle `mem_wb_data=0xDEADBEEF`.
- Two consecutive loads, each with a 1-cycle response delay:
  - `MA_stall` pattern is 1,0,1,0.
  - The second `dmem_read` is continuous from the cycle after the first resp.
  - The two results appear in order.
- Reset asserted in BUSY, 1 cycle after a load request:
  - `dmem_read`=0 and all outputs are 0 in the following cycle.
  - FSM is IDLE.
  - The next add passes through with no stall.
